// File: rtl/stage3_bus_arb_pkg.sv
// Shared types for the stage3 fetch/data bus arbiter.
// Holds the FSM encoding, the latched request bundle and the pick rule.
package stage3_bus_arb_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GNT_I,
        ARB_GNT_D
    } arb_state_t;

    typedef struct packed {
        word_t       addr;
        word_t       wdata;
        logic [3:0]  byte_en;
        logic        ren;
        logic        wen;
    } bus_req_t;

    // Data wins unless fetch is waiting and has already been passed over
    // the maximum number of times.
    function automatic arb_state_t arb_pick(
        input logic i_ok,
        input logic d_ok,
        input logic starved
    );
        arb_state_t s;
        s = ARB_IDLE;
        if (d_ok && (!i_ok || !starved)) begin
            s = ARB_GNT_D;
        end else if (i_ok) begin
            s = ARB_GNT_I;
        end
        return s;
    endfunction

endpackage

// File: rtl/generic_bus_if.sv
// Generic request/busy bus between a requester (cpu side) and a responder.
// Signals: addr, wdata, rdata, ren, wen, busy, byte_en, error.
interface generic_bus_if;
    import stage3_bus_arb_pkg::*;

    word_t       addr;
    word_t       wdata;
    word_t       rdata;
    logic        ren;
    logic        wen;
    logic        busy;
    logic [3:0]  byte_en;
    logic        error;

    // Responder view: receives the request, returns busy/rdata/error.
    modport generic_bus (
        input  addr, ren, wen, wdata, byte_en,
        output rdata, busy, error
    );

    // Requester view: drives the request, observes busy/rdata/error.
    modport cpu (
        output addr, ren, wen, wdata, byte_en,
        input  rdata, busy, error
    );

endinterface

// File: rtl/stage3_bus_arbiter_req_latch.sv
// bus_req_latch: load-enabled register holding the granted request.
// Ports: clk, clr_n (sync active-low clear), load, req_in, req_q.
module bus_req_latch
    import stage3_bus_arb_pkg::*;
(
    input  logic     clk,
    input  logic     clr_n,
    input  logic     load,
    input  bus_req_t req_in,
    output bus_req_t req_q
);

    bus_req_t req_d;

    always_comb begin
        req_d = req_q;
        if (load) begin
            req_d = req_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            req_q <= '0;
        end else begin
            req_q <= req_d;
        end
    end

endmodule

// File: rtl/stage3_bus_arbiter.sv
// Arbitrates fetch (igen) and data (dgen) onto one downstream bus.
// Ports: CLK, nRST (sync active-low), igen/dgen responders, out requester.
module stage3_bus_arbiter
    import stage3_bus_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                   CLK,
    input  logic                   nRST,
    generic_bus_if.generic_bus     igen_bus_if,
    generic_bus_if.generic_bus     dgen_bus_if,
    generic_bus_if.cpu             out_gen_bus_if
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [CNT_W-1:0]  starve_cnt_q;
    logic [CNT_W-1:0]  starve_cnt_d;

    bus_req_t          lat_q;
    bus_req_t          lat_in;
    logic              lat_load;

    logic              i_pend;
    logic              d_pend;
    logic              gnt_i;
    logic              gnt_d;
    logic              done;
    logic              i_match;
    logic              d_match;
    logic              deliver_i;
    logic              deliver_d;
    logic              arb_en;
    logic              i_ok;
    logic              d_ok;
    arb_state_t        pick;

    // Fetch is read-only; its write-side fields are never used.
    logic              unused_ifields;
    assign unused_ifields = ^{igen_bus_if.wen,
                              igen_bus_if.wdata,
                              igen_bus_if.byte_en};

    assign i_pend = igen_bus_if.ren;
    assign d_pend = dgen_bus_if.ren | dgen_bus_if.wen;

    assign gnt_i = (state_q == ARB_GNT_I);
    assign gnt_d = (state_q == ARB_GNT_D);
    assign done  = (gnt_i | gnt_d) & ~out_gen_bus_if.busy;

    // A result is handed back only if the requester is still asking for
    // the same address; a flushed or redirected request gets nothing.
    assign i_match = i_pend && (igen_bus_if.addr == lat_q.addr);
    assign d_match = d_pend && (dgen_bus_if.addr == lat_q.addr);

    assign deliver_i = gnt_i & done & i_match;
    assign deliver_d = gnt_d & done & d_match;

    // A delivered request is still visible during its completion cycle,
    // so it must not win the re-arbitration that happens in that cycle.
    assign arb_en = (state_q == ARB_IDLE) | done;
    assign i_ok   = i_pend & ~deliver_i;
    assign d_ok   = d_pend & ~deliver_d;
    assign pick   = arb_pick(i_ok, d_ok, starve_cnt_q >= LIMIT_C);

    always_comb begin
        state_d  = state_q;
        lat_load = 1'b0;
        if (arb_en) begin
            state_d  = pick;
            lat_load = (pick != ARB_IDLE);
        end
    end

    always_comb begin
        lat_in = '0;
        if (pick == ARB_GNT_D) begin
            lat_in.addr    = dgen_bus_if.addr;
            lat_in.wdata   = dgen_bus_if.wdata;
            lat_in.byte_en = dgen_bus_if.byte_en;
            lat_in.ren     = dgen_bus_if.ren;
            lat_in.wen     = dgen_bus_if.wen;
        end else begin
            lat_in.addr    = igen_bus_if.addr;
            lat_in.wdata   = '0;
            lat_in.byte_en = 4'b1111;
            lat_in.ren     = 1'b1;
            lat_in.wen     = 1'b0;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_ok) begin
            starve_cnt_d = '0;
        end else if (lat_load && pick == ARB_GNT_I) begin
            starve_cnt_d = '0;
        end else if (lat_load && pick == ARB_GNT_D) begin
            if (starve_cnt_q != LIMIT_C) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    bus_req_latch u_req_latch (
        .clk    (CLK),
        .clr_n  (nRST),
        .load   (lat_load),
        .req_in (lat_in),
        .req_q  (lat_q)
    );

    // Downstream is driven only from the latch; strobes drop in IDLE.
    assign out_gen_bus_if.addr    = lat_q.addr;
    assign out_gen_bus_if.wdata   = lat_q.wdata;
    assign out_gen_bus_if.byte_en = lat_q.byte_en;
    assign out_gen_bus_if.ren     = (gnt_i | gnt_d) & lat_q.ren;
    assign out_gen_bus_if.wen     = (gnt_i | gnt_d) & lat_q.wen;

    assign igen_bus_if.busy  = ~deliver_i;
    assign igen_bus_if.rdata = deliver_i ? out_gen_bus_if.rdata : '0;
    assign igen_bus_if.error = deliver_i & out_gen_bus_if.error;

    assign dgen_bus_if.busy  = ~deliver_d;
    assign dgen_bus_if.rdata = deliver_d ? out_gen_bus_if.rdata : '0;
    assign dgen_bus_if.error = deliver_d & out_gen_bus_if.error;

endmodule

// File: tb/tb_stage3_bus_arbiter.sv
// Directed bench for stage3_bus_arbiter with a wait-state memory model.
// Ports: none; drives igen/dgen requesters and responds on the out bus.
module tb_stage3_bus_arbiter;

    logic CLK = 1'b0;
    logic nRST;

    generic_bus_if ibus ();
    generic_bus_if dbus ();
    generic_bus_if obus ();

    stage3_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .igen_bus_if    (ibus),
        .dgen_bus_if    (dbus),
        .out_gen_bus_if (obus)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem_wait = 0;
    logic [31:0] mem_rdata = 0;
    logic        mem_err = 1'b0;
    logic [31:0] wcnt = 0;
    logic        oreq;

    assign oreq       = obus.ren | obus.wen;
    assign obus.busy  = !(oreq && wcnt == mem_wait);
    assign obus.rdata = mem_rdata;
    assign obus.error = mem_err;

    always @(posedge CLK) begin
        if (!oreq || !obus.busy) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    localparam logic [31:0] DA0 = 32'h9000_0000;
    localparam logic [31:0] DA1 = 32'h9000_0004;

    initial begin
        nRST = 1'b0;
        ibus.ren = 0; ibus.wen = 0; ibus.addr = 0;
        ibus.wdata = 0; ibus.byte_en = 0;
        dbus.ren = 0; dbus.wen = 0; dbus.addr = 0;
        dbus.wdata = 0; dbus.byte_en = 0;
        tick();
        tick();

        // reset state
        chk("rst_oren", 32'(obus.ren), 32'd0);
        chk("rst_owen", 32'(obus.wen), 32'd0);
        chk("rst_oaddr", obus.addr, 32'd0);
        chk("rst_owdata", obus.wdata, 32'd0);
        chk("rst_obe", 32'(obus.byte_en), 32'd0);
        chk("rst_ibusy", 32'(ibus.busy), 32'd1);
        chk("rst_dbusy", 32'(dbus.busy), 32'd1);
        chk("rst_irdata", ibus.rdata, 32'd0);
        chk("rst_drdata", dbus.rdata, 32'd0);
        chk("rst_ierr", 32'(ibus.error), 32'd0);
        chk("rst_derr", 32'(dbus.error), 32'd0);

        // single fetch, 2 wait states
        nRST = 1'b1;
        ibus.ren = 1; ibus.addr = 32'h8000_0000;
        mem_wait = 2; mem_rdata = 32'h0000_0013;
        #1;
        chk("f_idle_oren", 32'(obus.ren), 32'd0);
        tick();
        chk("f_oren", 32'(obus.ren), 32'd1);
        chk("f_oaddr", obus.addr, 32'h8000_0000);
        chk("f_obe", 32'(obus.byte_en), 32'hf);
        chk("f_ibusy1", 32'(ibus.busy), 32'd1);
        tick();
        chk("f_ibusy2", 32'(ibus.busy), 32'd1);
        tick();
        chk("f_ibusy_done", 32'(ibus.busy), 32'd0);
        chk("f_irdata", ibus.rdata, 32'h0000_0013);
        ibus.ren = 0;
        tick();
        chk("f_back_idle", 32'(obus.ren), 32'd0);

        // simultaneous i read and d write
        ibus.ren = 1; ibus.addr = 32'h8000_0004;
        dbus.wen = 1; dbus.addr = 32'h8000_1000;
        dbus.wdata = 32'hDEAD_BEEF; dbus.byte_en = 4'b0011;
        mem_wait = 0; mem_rdata = 32'h0000_1111;
        tick();
        chk("s_owen", 32'(obus.wen), 32'd1);
        chk("s_oren_d", 32'(obus.ren), 32'd0);
        chk("s_oaddr_d", obus.addr, 32'h8000_1000);
        chk("s_owdata", obus.wdata, 32'hDEAD_BEEF);
        chk("s_obe_d", 32'(obus.byte_en), 32'h3);
        chk("s_dbusy", 32'(dbus.busy), 32'd0);
        chk("s_ibusy_wait", 32'(ibus.busy), 32'd1);
        dbus.wen = 0;
        tick();
        chk("s_oren_i", 32'(obus.ren), 32'd1);
        chk("s_owen_i", 32'(obus.wen), 32'd0);
        chk("s_oaddr_i", obus.addr, 32'h8000_0004);
        chk("s_owdata_i", obus.wdata, 32'd0);
        chk("s_obe_i", 32'(obus.byte_en), 32'hf);
        chk("s_ibusy", 32'(ibus.busy), 32'd0);
        chk("s_irdata", ibus.rdata, 32'h0000_1111);
        ibus.ren = 0;
        tick();
        chk("s_idle", 32'(obus.ren | obus.wen), 32'd0);

        // starvation: d redirects every cycle while i waits
        ibus.ren = 1; ibus.addr = 32'h8000_0008;
        dbus.ren = 1; dbus.addr = DA0;
        tick();
        for (int k = 1; k <= 4; k++) begin
            dbus.addr = (k % 2 == 1) ? DA1 : DA0;
            #1;
            chk($sformatf("st_oaddr%0d", k), obus.addr,
                (k % 2 == 1) ? DA0 : DA1);
            chk($sformatf("st_dbusy%0d", k), 32'(dbus.busy), 32'd1);
            chk($sformatf("st_cnt%0d", k), 32'(dut.starve_cnt_q),
                32'(k));
            tick();
        end
        dbus.ren = 0;
        #1;
        chk("st_igrant", obus.addr, 32'h8000_0008);
        chk("st_ibusy", 32'(ibus.busy), 32'd0);
        chk("st_cnt_clr", 32'(dut.starve_cnt_q), 32'd0);
        ibus.ren = 0;
        tick();
        chk("st_idle", 32'(obus.ren), 32'd0);

        // fetch flush mid-grant, then redirect
        ibus.ren = 1; ibus.addr = 32'h8000_0020;
        mem_wait = 3;
        tick();
        chk("fl_oren", 32'(obus.ren), 32'd1);
        chk("fl_oaddr", obus.addr, 32'h8000_0020);
        tick();
        ibus.ren = 0;
        #1;
        chk("fl_oren_hold", 32'(obus.ren), 32'd1);
        chk("fl_ibusy1", 32'(ibus.busy), 32'd1);
        tick();
        ibus.ren = 1; ibus.addr = 32'h8000_0040;
        #1;
        chk("fl_oaddr_hold", obus.addr, 32'h8000_0020);
        chk("fl_ibusy2", 32'(ibus.busy), 32'd1);
        tick();
        chk("fl_obusy_done", 32'(obus.busy), 32'd0);
        chk("fl_ibusy_drop", 32'(ibus.busy), 32'd1);
        chk("fl_irdata", ibus.rdata, 32'd0);
        tick();
        mem_wait = 0;
        #1;
        chk("fl_new_oaddr", obus.addr, 32'h8000_0040);
        chk("fl_new_oren", 32'(obus.ren), 32'd1);
        chk("fl_new_ibusy", 32'(ibus.busy), 32'd0);
        ibus.ren = 0;
        tick();
        chk("fl_idle", 32'(obus.ren), 32'd0);

        // downstream error on a data read
        dbus.ren = 1; dbus.addr = 32'h8000_2000;
        mem_wait = 1; mem_err = 1; mem_rdata = 32'hCAFE_0001;
        tick();
        chk("er_dbusy1", 32'(dbus.busy), 32'd1);
        chk("er_derr1", 32'(dbus.error), 32'd0);
        tick();
        chk("er_dbusy", 32'(dbus.busy), 32'd0);
        chk("er_derr", 32'(dbus.error), 32'd1);
        chk("er_drdata", dbus.rdata, 32'hCAFE_0001);
        chk("er_ierr", 32'(ibus.error), 32'd0);
        chk("er_ibusy", 32'(ibus.busy), 32'd1);
        dbus.ren = 0; mem_err = 0;
        tick();
        chk("er_idle", 32'(obus.ren), 32'd0);

        // reset during a data grant
        dbus.ren = 1; dbus.addr = 32'h8000_3000;
        ibus.ren = 1; ibus.addr = 32'h8000_0080;
        mem_wait = 3;
        tick();
        chk("rs_oren", 32'(obus.ren), 32'd1);
        chk("rs_oaddr", obus.addr, 32'h8000_3000);
        nRST = 0;
        tick();
        chk("rs_oren0", 32'(obus.ren), 32'd0);
        chk("rs_owen0", 32'(obus.wen), 32'd0);
        chk("rs_oaddr0", obus.addr, 32'd0);
        chk("rs_ibusy", 32'(ibus.busy), 32'd1);
        chk("rs_dbusy", 32'(dbus.busy), 32'd1);
        chk("rs_cnt", 32'(dut.starve_cnt_q), 32'd0);
        nRST = 1;
        tick();
        mem_wait = 0;
        #1;
        chk("rs_d_again", obus.addr, 32'h8000_3000);
        chk("rs_d_oren", 32'(obus.ren), 32'd1);
        chk("rs_d_busy", 32'(dbus.busy), 32'd0);
        dbus.ren = 0;
        tick();
        chk("rs_i_addr", obus.addr, 32'h8000_0080);
        chk("rs_i_busy", 32'(ibus.busy), 32'd0);
        ibus.ren = 0;
        tick();
        chk("rs_idle", 32'(obus.ren), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage3_bus_arbiter.md
# stage3_bus_arbiter

Two-requester arbiter that shares one external generic bus between the stage3 fetch stage's instruction port and the memory stage's data port. It sits between the pipeline's `igen_bus_if` and `dgen_bus_if` and the single downstream memory or cache bus. Data accesses have priority, with a starvation limit that guarantees forward progress to fetch. Each granted request is latched and held on the downstream bus until it completes, even if the requester withdraws it.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive data grants issued while fetch waits, after which fetch wins the next arbitration.

Ports:
- `CLK`  in  1  clock.
- `nRST`  in  1  reset; one clock, reset is synchronous and active-low.
- `igen_bus_if`  generic_bus_if.generic_bus  —  instruction requester (fetch); read-only, wen ignored.
- `dgen_bus_if`  generic_bus_if.generic_bus  —  data requester (memory stage).
- `out_gen_bus_if`  generic_bus_if.cpu  —  downstream shared bus.

## Operation
Generic bus rules:
- Requester holds `ren`/`wen`, `addr`, `wdata`, `byte_en` until it sees `busy`=0.
- `busy`=0 marks the completion cycle; `rdata`/`error` are valid only then.
- Requester-side `busy` is 1 in every other cycle.

FSM states: IDLE, GNT_I, GNT_D.
- IDLE, arbitration:
  - d pending (`ren|wen`) and (i not pending or `starve_cnt` < `STARVE_LIMIT`) → GNT_D.
  - Else i pending → GNT_I.
  - Else stay in IDLE.
- On the transition into a GNT state, latch the winner's addr, wdata, byte_en, ren, wen (i: wen=0, wdata=0, byte_en=4'b1111).
- GNT_x: downstream bus is driven only from the latch. Stay until `out.busy`=0.
- Completion cycle:
  - If requester x still asserts its request with addr equal to the latched addr, forward `rdata`/`error` and drive x.`busy`=0 combinationally.
  - Otherwise (flushed or redirected), discard the result; x.`busy` stays 1.
- Exit from completion: re-arbitrate with the IDLE rules, excluding the just-served request if it was delivered.
  - The other requester pending → go directly to its GNT state (back-to-back, no idle cycle).
  - Nothing pending → IDLE.
- `starve_cnt` (width clog2(`STARVE_LIMIT`+1)):
  - +1 on each GNT_D entry while i is pending; saturates at `STARVE_LIMIT`.
  - Cleared on GNT_I entry and whenever i is not pending.
- Downstream `ren`/`wen` are 0 in IDLE. `addr`/`wdata` hold their last latched values.

## Timing
- Reset values:
  - state IDLE, `starve_cnt` 0, latch 0.
  - `out.ren`=`out.wen`=0, `out.addr`=0, `out.wdata`=0, `out.byte_en`=0.
  - `igen.busy`=`dgen.busy`=1, `igen.rdata`=`dgen.rdata`=0, `error`=0.
- Latency:
  - Request first seen in IDLE in cycle N → downstream request in N+1.
  - Downstream completes in cycle M → requester sees `busy`=0 in M.
  - Minimum requester-visible latency from IDLE: 2 cycles with a zero-wait downstream.
- A back-to-back switch costs no bubble: the other requester's downstream request appears at M+1.
- Simultaneous i and d requests with `starve_cnt`<`STARVE_LIMIT`: d is granted first, i next.
- Request withdrawn mid-flight: the downstream transaction still runs to completion. A new request from the same requester is arbitrated only after that completion.
- `error` is forwarded only under the same conditions as `rdata`.
- Synchronous reset asserted mid-transaction: all state returns to reset values at the next edge and the downstream request drops. The downstream side must tolerate an abandoned request.
- Data writes: latched `wdata`/`byte_en` are held constant for the whole grant.

## Structure
- `stage3_bus_arb_pkg`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_I, ARB_GNT_D} arb_state_t`
  - `typedef struct packed {word_t addr; word_t wdata; logic [3:0] byte_en; logic ren; logic wen;} bus_req_t`
  - default `STARVE_LIMIT` constant.
- One sub-module, `bus_req_latch`: a load-enabled register of `bus_req_t` with synchronous active-low clear. It is instantiated once for the winner.
- FSM, `starve_cnt`, and the delivery-match compare live in the top module.

## Test plan
- Single fetch read, addr 0x80000000, downstream 2 wait states returning 0x00000013:
  - `out.ren` rises 1 cycle after `igen.ren`.
  - `igen.busy`=0 with rdata 0x00000013 exactly in the downstream completion cycle.
- i and d both request in the same cycle (d write 0x80001000, data 0xDEADBEEF, byte_en 4'b0011):
  - The d write is issued first with those exact latched values.
  - The i read follows at the next cycle with no IDLE bubble.
- d requests continuously while i is pending, `STARVE_LIMIT`=4:
  - Exactly 4 d grants occur, then an i grant.
  - `starve_cnt` returns to 0.
- Fetch flushes (`ren` drops) in the second cycle of a GNT_I with downstream busy 3 cycles:
  - The downstream read completes.
  - `igen.busy` stays 1 and no rdata is delivered.
  - A new i request at addr 0x80000040 is granted only after the completion.
- Downstream `error`=1 on a d read:
  - `dgen.busy`=0 and `dgen.error`=1 in the same cycle.
  - `igen.error` stays 0.
- `nRST` low for 1 cycle during a pending GNT_D:
  - Next cycle state is IDLE, `out.ren`=`out.wen`=0, and both requester `busy`=1.
  - The requests are re-arbitrated afterwards.
